// File: rtl/astable555_cv_osc.sv
// Sample-stepped 555 astable stage: the timing cap charges toward vcc and discharges toward 0 between CV/2 and CV thresholds.
// Optional period measurement outputs are enabled with `define ASTABLE555_PERIOD_COUNT_EN.
module astable555_cv_osc #(
  parameter logic [15:0] K_CHARGE    = 16'd32768,
  parameter logic [15:0] K_DISCHARGE = 16'd32768,
  parameter logic [15:0] CV_MIN      = 16'd256,
  parameter logic [15:0] CV_MARGIN   = 16'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic        walk_en,
  input  logic [15:0] vcc,
  input  logic [15:0] v_control,
  output logic        out,
  output logic [15:0] out_level,
  output logic [15:0] v_cap,
  output logic        cycle_done
`ifdef ASTABLE555_PERIOD_COUNT_EN
  ,
  output logic [15:0] period,
  output logic        period_valid
`endif
);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_CHARGE    = 2'd1,
    ST_DISCHARGE = 2'd2
  } state_t;

  state_t state;
  state_t nxt_state;

  logic [16:0] floor_sum;
  logic [15:0] ceil_v;
  logic [15:0] upper;
  logic [15:0] lower;

  logic [15:0] chg_diff;
  logic [31:0] chg_prod;
  logic [15:0] chg_step;
  logic [15:0] chg_frac_unused;
  logic [15:0] chg_vcap;

  logic [31:0] dis_prod;
  logic [15:0] dis_step;
  logic [15:0] dis_frac_unused;
  logic [15:0] dis_vcap;

  logic [15:0] nxt_vcap;
  logic        nxt_done;

  // Upper threshold stays inside [CV_MIN, vcc-CV_MARGIN]; collapses to CV_MIN when the supply is too low.
  always_comb begin
    floor_sum = {1'b0, CV_MIN} + {1'b0, CV_MARGIN};
    ceil_v    = vcc - CV_MARGIN;
    upper     = CV_MIN;
    if ({1'b0, vcc} >= floor_sum) begin
      if (v_control < CV_MIN)
        upper = CV_MIN;
      else if (v_control > ceil_v)
        upper = ceil_v;
      else
        upper = v_control;
    end
    lower = upper >> 1;
  end

  // Step can never exceed the remaining distance, so v_cap+step stays within vcc and v_cap-step stays >= 0.
  always_comb begin
    chg_diff = (vcc > v_cap) ? (vcc - v_cap) : 16'd0;
    chg_prod = 32'(chg_diff) * 32'(K_CHARGE);
    {chg_step, chg_frac_unused} = chg_prod;
    if (chg_step == 16'd0 && chg_diff != 16'd0)
      chg_step = 16'd1;
    chg_vcap = v_cap + chg_step;

    dis_prod = 32'(v_cap) * 32'(K_DISCHARGE);
    {dis_step, dis_frac_unused} = dis_prod;
    if (dis_step == 16'd0 && v_cap != 16'd0)
      dis_step = 16'd1;
    dis_vcap = v_cap - dis_step;
  end

  always_comb begin
    nxt_state = state;
    nxt_vcap  = v_cap;
    nxt_done  = 1'b0;
    if (!walk_en) begin
      nxt_state = ST_HOLD;
      nxt_vcap  = dis_vcap;
    end else begin
      case (state)
        ST_HOLD: nxt_state = ST_CHARGE;
        ST_CHARGE: begin
          nxt_vcap = chg_vcap;
          if (chg_vcap >= upper)
            nxt_state = ST_DISCHARGE;
        end
        ST_DISCHARGE: begin
          nxt_vcap = dis_vcap;
          if (dis_vcap <= lower) begin
            nxt_state = ST_CHARGE;
            nxt_done  = 1'b1;
          end
        end
        default: nxt_state = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HOLD;
      out        <= 1'b0;
      out_level  <= 16'd0;
      v_cap      <= 16'd0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (sample_en) begin
        state      <= nxt_state;
        v_cap      <= nxt_vcap;
        out        <= (nxt_state == ST_CHARGE);
        out_level  <= (nxt_state == ST_CHARGE) ? vcc : 16'd0;
        cycle_done <= nxt_done;
      end
    end
  end

`ifdef ASTABLE555_PERIOD_COUNT_EN
  logic [15:0] period_cnt;
  logic [15:0] cnt_inc;

  assign cnt_inc = (period_cnt == 16'hFFFF) ? 16'hFFFF : period_cnt + 16'd1;

  // Count covers every running update, including the one that closes the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt   <= 16'd0;
      period       <= 16'd0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (sample_en) begin
        if (!walk_en) begin
          period_cnt <= 16'd0;
          period     <= 16'd0;
        end else if (nxt_done) begin
          period       <= cnt_inc;
          period_valid <= 1'b1;
          period_cnt   <= 16'd0;
        end else if (state != ST_HOLD) begin
          period_cnt <= cnt_inc;
        end
      end
    end
  end
`endif

endmodule

// File: doc/astable555_cv_osc.md
Name: astable555_cv_osc

Overview:
- Fixed-point, sample-stepped model of the 555 astable stage that sits directly downstream of the walk-enable control-voltage filter.
- Takes the filtered control voltage v_control and the walk enable (555 RESET pin), and integrates the timing-capacitor voltage between CV/2 and CV thresholds.
- Produces the oscillator square wave and its analog level for the next discrete stage / mixer.
- One update per sample_en strobe; all arithmetic is unsigned Q4.12 volts (4096 = 1.0 V).

Parameters:
- K_CHARGE, 16'd32768, charge coefficient, Q0.16 (dt/(Ra+Rb)C).
- K_DISCHARGE, 16'd32768, discharge coefficient, Q0.16 (dt/(Rb·C)).
- CV_MIN, 16'd256, lower clamp on the upper threshold (0.0625 V).
- CV_MARGIN, 16'd64, upper threshold held at least this far below vcc.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sample_en  in  1  one-cycle update strobe.
- walk_en  in  1  555 RESET pin; 0 = hold oscillator off.
- vcc  in  16  supply voltage, Q4.12.
- v_control  in  16  control voltage from the upstream filter, Q4.12.
- out  out  1  555 output, 1 = high.
- out_level  out  16  vcc when out=1, else 0, Q4.12.
- v_cap  out  16  capacitor voltage, Q4.12.
- cycle_done  out  1  one-cycle pulse on each DISCHARGE→CHARGE transition.

Behaviour:
- Reset values: state=HOLD, out=0, out_level=0, v_cap=0, cycle_done=0. rst takes priority over sample_en.
- All state updates happen only on a cycle with sample_en=1. Results are registered and visible the next cycle (latency 1). With sample_en=0 everything holds, and cycle_done=0.
- Thresholds, computed combinationally each update:
  - upper = clamp(v_control, CV_MIN, vcc−CV_MARGIN). If vcc<CV_MIN+CV_MARGIN, upper=CV_MIN.
  - lower = upper>>1.
- Step arithmetic: 16×16 unsigned multiply to 32 bits, then >>16 (truncate).
  - Charge step = ((vcc−v_cap)·K_CHARGE)>>16, forced to 1 if the result is 0 and vcc>v_cap. It is 0 if v_cap≥vcc.
  - Discharge step = (v_cap·K_DISCHARGE)>>16, forced to 1 if the result is 0 and v_cap>0.
  - v_cap never wraps: charge saturates at vcc, discharge floors at 0.
- States:
  - HOLD: out=0. v_cap applies the discharge step each update. If walk_en=1 at an update → CHARGE; that update performs no step (transition only).
  - CHARGE: out=1. v_cap_new = v_cap+charge step. If v_cap_new≥upper → DISCHARGE (out=0 next cycle).
  - DISCHARGE: out=0. v_cap_new = v_cap−discharge step. If v_cap_new≤lower → CHARGE, with cycle_done=1 for that one cycle.
- Threshold comparisons use the updated v_cap_new, so one update can both step and change state.
- walk_en=0 at any update, in any state, forces HOLD immediately. That update applies the discharge step and sets out=0; walk_en has priority over threshold transitions.
- v_control changing mid-cycle takes effect at the next update.
  - A new upper below v_cap while in CHARGE switches to DISCHARGE on that update.
  - A new lower above v_cap while in DISCHARGE switches to CHARGE on that update.
- out_level is registered alongside out and uses the vcc value sampled at that update.

Optional Feature:
- Macro: ASTABLE555_PERIOD_COUNT_EN.
- When defined, adds two outputs: period (16 bits) and period_valid (1 bit).
  - An internal counter increments on each sample_en while in CHARGE or DISCHARGE, saturating at 16'hFFFF.
  - On cycle_done, period ← count including the current update, period_valid pulses 1, and the counter restarts at 0.
  - Entering HOLD or rst clears the counter, period and period_valid.
- When undefined, the ports and logic are absent, and the remaining behaviour is bit-identical.

Test Plan:
- Reset, then walk_en=1, vcc=20480, v_control=13653, one sample_en: state CHARGE, out=1, out_level=20480, v_cap=0.
- Continue with default K and one strobe per 4 clocks: v_cap sequence 10240, 15360 (→DISCHARGE, out=0), 7680, 3840 (→CHARGE, cycle_done=1), 12160, 16320 (→DISCHARGE). With the feature enabled: period=4, period_valid pulse.
- v_control=20480 (≥vcc): upper=20416, and the oscillator still toggles. v_control=0: upper=256, lower=128, no divide/wrap anomalies.
- walk_en dropped mid-CHARGE at v_cap=10240: next update gives HOLD, out=0, v_cap=5120, then 2560, decaying to 0 and staying at 0.
- rst asserted together with sample_en mid-DISCHARGE: all outputs take reset values the next cycle, and no cycle_done is emitted.
- K_DISCHARGE=1, v_cap=5: each update decrements by exactly 1 (minimum-step rule), reaching and holding 0.
